// File: rtl/muldiv_hilo.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Divider is present only when MULDIV_DIV_EN is defined.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
`ifdef MULDIV_DIV_EN
  logic             div_q, div_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
`endif

  logic go, load, step, fin, mv_ok;

`ifdef MULDIV_DIV_EN
  assign go = start & (state_q == IDLE);
`else
  // Without the divider a DIV/DIVU request is simply not a start.
  assign go = start & ~op[1] & (state_q == IDLE);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = CALC;
      CALC:    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    load   = go;
    step   = (state_q == CALC);
    fin    = (state_q == FIX);
    mv_ok  = (state_q == IDLE) & ~start;
    done_d = fin;
  end

  assign stall = busy & hilo_req;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

  logic             sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_step, prod;

  assign sgn   = ~op[0];
  assign sa    = sgn & a[WIDTH-1];
  assign sb    = sgn & b[WIDTH-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  // Multiply: add multiplicand into the upper half, shift right.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? opb_q : '0)};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod     = neg_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh, diff;
  logic [W2-1:0]    div_step;
  logic [WIDTH-1:0] quo, rem;

  // Restoring step: remainder in the upper half, quotient shifts in below.
  assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, opb_q};
  assign div_step = diff[WIDTH]
                  ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[W2-1:WIDTH];
`endif

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opb_d  = opb_q;
    neg_d  = neg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
`ifdef MULDIV_DIV_EN
    div_d  = div_q;
    negr_d = negr_q;
    dz_d   = dz_q;
`endif
    if (load) begin
      cnt_d = '0;
      neg_d = sa ^ sb;
      acc_d = {{WIDTH{1'b0}}, mag_b};
      opb_d = mag_a;
`ifdef MULDIV_DIV_EN
      div_d  = op[1];
      negr_d = sa;
      dz_d   = (b == '0);
      if (op[1]) begin
        acc_d = {{WIDTH{1'b0}}, mag_a};
        opb_d = mag_b;
      end
`endif
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = mul_step;
`ifdef MULDIV_DIV_EN
      if (div_q) acc_d = div_step;
`endif
    end
    if (fin) begin
      {hi_d, lo_d} = prod;
`ifdef MULDIV_DIV_EN
      if (div_q) begin
        lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
        hi_d = negr_q ? -rem : rem;
      end
`endif
    end else if (mv_ok) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q  <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      neg_q  <= neg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
`ifdef MULDIV_DIV_EN
      div_q  <= div_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
`endif
    end
  end

endmodule
